// File: rtl/char_move_ctrl.sv
// Movement controller for one platformer character: divided horizontal motion,
// edge-triggered multi-jump with ramped rise/fall speeds, and registered outputs.
module char_move_ctrl #(
  parameter int X_W          = 10,
  parameter int Y_W          = 10,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 1023,
  parameter int FLOOR_Y      = 767,
  parameter int CHAR_W       = 32,
  parameter int CHAR_H       = 32,
  parameter int SPAWN_X      = 100,
  parameter int SPAWN_Y      = 700,
  parameter int DIV_W        = 20,
  parameter int RUN_DIV      = 400000,
  parameter int AIR_DIV      = 700000,
  parameter int JUMP_DIV0    = 200000,
  parameter int JUMP_DIV_MAX = 800000,
  parameter int FALL_DIV0    = 800000,
  parameter int FALL_DIV_MIN = 150000,
  parameter int DIV_STEP     = 20000,
  parameter int JUMP_H       = 200,
  parameter int DECEL_AT     = 175,
  parameter int MAX_JUMPS    = 1,
  parameter int ANIM_FRAMES  = 8,
  parameter int ANIM_PX      = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           respawn,
  input  logic           freeze,
  input  logic           left,
  input  logic           right,
  input  logic           jump,
  input  logic           on_ground,
  input  logic           ceiling_hit,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [1:0]     state_o,
  output logic           facing_right,
  output logic [3:0]     anim_frame,
  output logic           jump_pulse,
  output logic           land_pulse
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_RISE = 2'b11,
    S_FALL = 2'b10
  } state_t;

  localparam int JL_W = $clog2(MAX_JUMPS + 1);
  localparam int AP_W = $clog2(ANIM_PX + 1);

  localparam logic [X_W:0]       X_LO     = (X_W+1)'(X_MIN);
  localparam logic [X_W:0]       X_HI     = (X_W+1)'(X_MAX - CHAR_W);
  localparam logic [Y_W:0]       Y_BOT    = (Y_W+1)'(FLOOR_Y - CHAR_H);
  localparam logic [X_W-1:0]     X_SPAWN  = X_W'(SPAWN_X);
  localparam logic [Y_W-1:0]     Y_SPAWN  = Y_W'(SPAWN_Y);
  localparam logic [DIV_W-1:0]   RUN_LAST = DIV_W'(RUN_DIV - 1);
  localparam logic [DIV_W-1:0]   AIR_LAST = DIV_W'(AIR_DIV - 1);
  localparam logic [DIV_W-1:0]   J0       = DIV_W'(JUMP_DIV0);
  localparam logic [DIV_W-1:0]   JMAX     = DIV_W'(JUMP_DIV_MAX);
  localparam logic [DIV_W-1:0]   JSAT     = DIV_W'(JUMP_DIV_MAX - DIV_STEP);
  localparam logic [DIV_W-1:0]   F0       = DIV_W'(FALL_DIV0);
  localparam logic [DIV_W-1:0]   FMIN     = DIV_W'(FALL_DIV_MIN);
  localparam logic [DIV_W-1:0]   FSAT     = DIV_W'(FALL_DIV_MIN + DIV_STEP);
  localparam logic [DIV_W-1:0]   STEP     = DIV_W'(DIV_STEP);
  localparam logic [Y_W-1:0]     RISE_TOP = Y_W'(JUMP_H);
  localparam logic [Y_W-1:0]     DECEL    = Y_W'(DECEL_AT);
  localparam logic [JL_W-1:0]    JL_MAX   = JL_W'(MAX_JUMPS);
  localparam logic [AP_W-1:0]    AP_LAST  = AP_W'(ANIM_PX - 1);
  localparam logic [3:0]         AF_LAST  = 4'(ANIM_FRAMES - 1);

  state_t            state_q, state_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic              facing_q, facing_d;
  logic [3:0]        anim_q, anim_d;
  logic [AP_W-1:0]   pix_q, pix_d;
  logic [DIV_W-1:0]  xdiv_q, xdiv_d;
  logic [DIV_W-1:0]  ydiv_q, ydiv_d;
  logic [DIV_W-1:0]  jdiv_q, jdiv_d;
  logic [DIV_W-1:0]  fdiv_q, fdiv_d;
  logic [Y_W-1:0]    rise_q, rise_d;
  logic [JL_W-1:0]   jumps_left_q, jumps_left_d;
  logic              jump_q, jump_q_d;
  logic              jump_pulse_q, jump_pulse_d;
  logic              land_pulse_q, land_pulse_d;

  logic              dir_r, dir_l, dir_any, jump_edge, grounded, airborne;
  logic              x_step, jump_start;
  logic [DIV_W-1:0]  x_last;
  logic [X_W:0]      x_next;
  logic [JL_W-1:0]   jumps_avail;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    facing_d     = facing_q;
    anim_d       = anim_q;
    pix_d        = pix_q;
    xdiv_d       = xdiv_q;
    ydiv_d       = ydiv_q;
    jdiv_d       = jdiv_q;
    fdiv_d       = fdiv_q;
    rise_d       = rise_q;
    jumps_left_d = jumps_left_q;
    jump_q_d     = jump_q;
    jump_pulse_d = 1'b0;
    land_pulse_d = 1'b0;

    dir_r       = right & ~left;
    dir_l       = left & ~right;
    dir_any     = dir_r | dir_l;
    jump_edge   = jump & ~jump_q;
    grounded    = on_ground | ({1'b0, y_q} == Y_BOT);
    airborne    = (state_q == S_RISE) || (state_q == S_FALL);
    x_last      = airborne ? AIR_LAST : RUN_LAST;
    x_step      = 1'b0;
    x_next      = '0;
    // The reload is seen by a jump in the same cycle, so a freshly landed
    // character can jump again immediately.
    jumps_avail = (!airborne && grounded) ? JL_MAX : jumps_left_q;
    jump_start  = jump_edge && (jumps_avail != '0);

    if (rst || respawn) begin
      state_d      = S_IDLE;
      x_d          = X_SPAWN;
      y_d          = Y_SPAWN;
      facing_d     = 1'b1;
      anim_d       = '0;
      pix_d        = '0;
      xdiv_d       = '0;
      ydiv_d       = '0;
      jdiv_d       = J0;
      fdiv_d       = F0;
      rise_d       = '0;
      jumps_left_d = JL_MAX;
      jump_q_d     = rst ? 1'b0 : jump;
    end else if (!freeze) begin
      jump_q_d = jump;

      if (dir_any) begin
        facing_d = dir_r;
        if (xdiv_q >= x_last) begin
          xdiv_d = '0;
          if (dir_r) begin
            x_next = {1'b0, x_q} + 1'b1;
            x_step = (x_next <= X_HI);
          end else begin
            x_next = {1'b0, x_q} - 1'b1;
            x_step = ({1'b0, x_q} > X_LO);
          end
          if (x_step) x_d = x_next[X_W-1:0];
        end else begin
          xdiv_d = xdiv_q + 1'b1;
        end
      end else begin
        xdiv_d = '0;
      end

      if (x_step && (state_q == S_RUN)) begin
        if (pix_q == AP_LAST) begin
          pix_d  = '0;
          anim_d = (anim_q == AF_LAST) ? 4'd0 : anim_q + 4'd1;
        end else begin
          pix_d = pix_q + 1'b1;
        end
      end

      if (!airborne && grounded) jumps_left_d = JL_MAX;

      if (jump_start) begin
        state_d      = S_RISE;
        jumps_left_d = jumps_avail - 1'b1;
        rise_d       = '0;
        jdiv_d       = J0;
        ydiv_d       = '0;
        jump_pulse_d = 1'b1;
      end else begin
        unique case (state_q)
          S_IDLE: if (dir_any) state_d = S_RUN;
          S_RUN: begin
            if (!grounded) begin
              state_d      = S_FALL;
              jumps_left_d = JL_MAX - 1'b1;
              fdiv_d       = F0;
              ydiv_d       = '0;
            end else if (!dir_any) begin
              state_d = S_IDLE;
            end
          end
          S_RISE: begin
            if ((rise_q == RISE_TOP) || ceiling_hit || (y_q == '0)) begin
              state_d = S_FALL;
              fdiv_d  = F0;
              ydiv_d  = '0;
            end else if (ydiv_q >= jdiv_q - 1'b1) begin
              ydiv_d = '0;
              y_d    = y_q - 1'b1;
              rise_d = rise_q + 1'b1;
              if (rise_q >= DECEL) jdiv_d = (jdiv_q >= JSAT) ? JMAX : jdiv_q + STEP;
            end else begin
              ydiv_d = ydiv_q + 1'b1;
            end
          end
          S_FALL: begin
            if (grounded) begin
              state_d      = dir_any ? S_RUN : S_IDLE;
              land_pulse_d = 1'b1;
              fdiv_d       = F0;
              ydiv_d       = '0;
            end else if (ydiv_q >= fdiv_q - 1'b1) begin
              ydiv_d = '0;
              if (({1'b0, y_q} + 1'b1) <= Y_BOT) y_d = y_q + 1'b1;
              fdiv_d = (fdiv_q <= FSAT) ? FMIN : fdiv_q - STEP;
            end else begin
              ydiv_d = ydiv_q + 1'b1;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end

      if ((state_d == S_IDLE) && (state_q != S_IDLE)) begin
        anim_d = '0;
        pix_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    state_q      <= state_d;
    x_q          <= x_d;
    y_q          <= y_d;
    facing_q     <= facing_d;
    anim_q       <= anim_d;
    pix_q        <= pix_d;
    xdiv_q       <= xdiv_d;
    ydiv_q       <= ydiv_d;
    jdiv_q       <= jdiv_d;
    fdiv_q       <= fdiv_d;
    rise_q       <= rise_d;
    jumps_left_q <= jumps_left_d;
    jump_q       <= jump_q_d;
    jump_pulse_q <= jump_pulse_d;
    land_pulse_q <= land_pulse_d;
  end

  assign x            = x_q;
  assign y            = y_q;
  assign state_o      = state_q;
  assign facing_right = facing_q;
  assign anim_frame   = anim_q;
  assign jump_pulse   = jump_pulse_q;
  assign land_pulse   = land_pulse_q;

endmodule

// File: tb/tb_char_move_ctrl.sv
// Bench for char_move_ctrl: directed scenarios, a cycle-level behavioural model
// compared every cycle, and hand-computed spot checks.
`timescale 1ns/1ps
module tb_char_move_ctrl;
  localparam int X_W = 10, Y_W = 10, X_MIN = 90, X_MAX = 142, FLOOR_Y = 742;
  localparam int CHAR_W = 32, CHAR_H = 32, SPAWN_X = 100, SPAWN_Y = 700, DIV_W = 8;
  localparam int RUN_DIV = 4, AIR_DIV = 6, JUMP_DIV0 = 2, JUMP_DIV_MAX = 8;
  localparam int FALL_DIV0 = 10, FALL_DIV_MIN = 4, DIV_STEP = 2, JUMP_H = 10;
  localparam int DECEL_AT = 6, MAX_JUMPS = 2, ANIM_FRAMES = 8, ANIM_PX = 2;
  localparam int IDLE = 0, RUN = 1, RISE = 3, FALL = 2;

  logic clk = 1'b0;
  logic rst = 1'b1, respawn = 1'b0, freeze = 1'b0;
  logic left = 1'b0, right = 1'b0, jump = 1'b0, on_ground = 1'b0, ceiling_hit = 1'b0;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [1:0] state_o;
  logic facing_right, jump_pulse, land_pulse;
  logic [3:0] anim_frame;

  int checks = 0, errors = 0;

  char_move_ctrl #(
    .X_W(X_W), .Y_W(Y_W), .X_MIN(X_MIN), .X_MAX(X_MAX), .FLOOR_Y(FLOOR_Y),
    .CHAR_W(CHAR_W), .CHAR_H(CHAR_H), .SPAWN_X(SPAWN_X), .SPAWN_Y(SPAWN_Y),
    .DIV_W(DIV_W), .RUN_DIV(RUN_DIV), .AIR_DIV(AIR_DIV), .JUMP_DIV0(JUMP_DIV0),
    .JUMP_DIV_MAX(JUMP_DIV_MAX), .FALL_DIV0(FALL_DIV0), .FALL_DIV_MIN(FALL_DIV_MIN),
    .DIV_STEP(DIV_STEP), .JUMP_H(JUMP_H), .DECEL_AT(DECEL_AT), .MAX_JUMPS(MAX_JUMPS),
    .ANIM_FRAMES(ANIM_FRAMES), .ANIM_PX(ANIM_PX)
  ) dut (
    .clk(clk), .rst(rst), .respawn(respawn), .freeze(freeze), .left(left),
    .right(right), .jump(jump), .on_ground(on_ground), .ceiling_hit(ceiling_hit),
    .x(x), .y(y), .state_o(state_o), .facing_right(facing_right),
    .anim_frame(anim_frame), .jump_pulse(jump_pulse), .land_pulse(land_pulse)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // behavioural model: plain integers, intervals counted in cycles
  int mx, my, mst, mface, manim, mpix, mxcnt, mycnt, mjint, mfint, mrise, mjumps;
  int mjprev, mjp, mlp;
  bit model_valid = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit dr, dl, moving, jedge, ground, air, moved;
    int avail, nx, old_st;
    if (rst || respawn) begin
      mx = SPAWN_X; my = SPAWN_Y; mst = IDLE; mface = 1; manim = 0; mpix = 0;
      mxcnt = 0; mycnt = 0; mjint = JUMP_DIV0; mfint = FALL_DIV0; mrise = 0;
      mjumps = MAX_JUMPS; mjp = 0; mlp = 0;
      mjprev = rst ? 0 : int'(jump);
      return;
    end
    if (freeze) begin
      mjp = 0; mlp = 0;
      return;
    end
    dr = right && !left;
    dl = left && !right;
    moving = dr || dl;
    jedge = jump && (mjprev == 0);
    mjprev = int'(jump);
    mjp = 0; mlp = 0;
    ground = on_ground || (my == FLOOR_Y - CHAR_H);
    air = (mst == RISE) || (mst == FALL);
    old_st = mst;
    moved = 0;
    if (moving) begin
      mface = dr;
      mxcnt++;
      if (mxcnt >= (air ? AIR_DIV : RUN_DIV)) begin
        mxcnt = 0;
        nx = dr ? mx + 1 : mx - 1;
        if (nx >= X_MIN && nx <= X_MAX - CHAR_W) begin mx = nx; moved = 1; end
      end
    end else mxcnt = 0;
    if (moved && old_st == RUN) begin
      mpix++;
      if (mpix == ANIM_PX) begin mpix = 0; manim = (manim + 1) % ANIM_FRAMES; end
    end
    avail = (!air && ground) ? MAX_JUMPS : mjumps;
    if (!air && ground) mjumps = MAX_JUMPS;
    if (jedge && avail > 0) begin
      mst = RISE; mjumps = avail - 1; mrise = 0; mjint = JUMP_DIV0; mycnt = 0; mjp = 1;
    end else if (old_st == IDLE) begin
      if (moving) mst = RUN;
    end else if (old_st == RUN) begin
      if (!ground) begin mst = FALL; mjumps = MAX_JUMPS - 1; mfint = FALL_DIV0; mycnt = 0; end
      else if (!moving) mst = IDLE;
    end else if (old_st == RISE) begin
      if (mrise == JUMP_H || ceiling_hit || my == 0) begin
        mst = FALL; mfint = FALL_DIV0; mycnt = 0;
      end else begin
        mycnt++;
        if (mycnt >= mjint) begin
          mycnt = 0;
          my--;
          if (mrise >= DECEL_AT) mjint = (mjint + DIV_STEP > JUMP_DIV_MAX) ? JUMP_DIV_MAX : mjint + DIV_STEP;
          mrise++;
        end
      end
    end else begin
      if (ground) begin
        mst = moving ? RUN : IDLE; mlp = 1; mfint = FALL_DIV0; mycnt = 0;
      end else begin
        mycnt++;
        if (mycnt >= mfint) begin
          mycnt = 0;
          if (my < FLOOR_Y - CHAR_H) my++;
          mfint = (mfint - DIV_STEP < FALL_DIV_MIN) ? FALL_DIV_MIN : mfint - DIV_STEP;
        end
      end
    end
    if (mst == IDLE && old_st != IDLE) begin manim = 0; mpix = 0; end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
    model_valid = 1'b1;
  end

  // scoreboard: every output against the model, once per cycle
  initial forever begin
    @(negedge clk);
    if (model_valid) begin
      check("x", int'(x), mx);
      check("y", int'(y), my);
      check("state", int'(state_o), mst);
      check("facing", int'(facing_right), mface);
      check("anim", int'(anim_frame), manim);
      check("jump_pulse", int'(jump_pulse), mjp);
      check("land_pulse", int'(land_pulse), mlp);
    end
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input int s, input int max_cyc, input string name);
    int n = 0;
    while (int'(state_o) != s && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(state_o), s);
  endtask

  int fall_exp[5] = '{10, 8, 6, 4, 4};

  initial begin
    int cnt, prev, pulses, ys, fx, fy, fs;
    cyc(3);
    rst = 1'b0; on_ground = 1'b1;
    cyc(10);
    check("reset_x", int'(x), 100);
    check("reset_y", int'(y), 700);
    check("reset_state", int'(state_o), IDLE);
    check("reset_facing", int'(facing_right), 1);
    check("reset_anim", int'(anim_frame), 0);
    check("reset_pulses", int'(jump_pulse) + int'(land_pulse), 0);

    // run right to the right wall
    right = 1'b1;
    cyc(40);
    check("run_x", int'(x), 110);
    check("run_anim", int'(anim_frame), 5);
    check("run_state", int'(state_o), RUN);
    cyc(8);
    check("right_wall_x", int'(x), 110);
    right = 1'b0;
    cyc(1);
    check("release_state", int'(state_o), IDLE);
    check("release_anim", int'(anim_frame), 0);

    // held jump: single pulse, full rise, ramped fall, landing
    jump = 1'b1;
    cyc(1);
    check("jump_pulse_start", int'(jump_pulse), 1);
    check("jump_state", int'(state_o), RISE);
    on_ground = 1'b0;
    pulses = 0; cnt = 0;
    while (int'(state_o) != FALL && cnt < 100) begin
      @(negedge clk); cnt++;
      if (jump_pulse) pulses++;
    end
    check("apex_state", int'(state_o), FALL);
    check("held_retrigger", pulses, 0);
    check("apex_y", int'(y), 690);
    for (int i = 0; i < 5; i++) begin
      cnt = 0; prev = int'(y);
      while (int'(y) == prev && cnt < 40) begin @(negedge clk); cnt++; end
      check("fall_interval", cnt, fall_exp[i]);
    end
    jump = 1'b0;
    on_ground = 1'b1;
    cyc(1);
    check("land_pulse", int'(land_pulse), 1);
    check("land_state", int'(state_o), IDLE);
    cyc(1);
    check("land_pulse_once", int'(land_pulse), 0);

    // double jump: RISE edge restarts, FALL edge ignored, landing reloads
    jump = 1'b1; cyc(1);
    check("dj_first", int'(jump_pulse), 1);
    jump = 1'b0; on_ground = 1'b0;
    cyc(4);
    jump = 1'b1; cyc(1);
    check("dj_second", int'(jump_pulse), 1);
    check("dj_second_state", int'(state_o), RISE);
    jump = 1'b0;
    wait_state(FALL, 100, "dj_fall");
    jump = 1'b1; cyc(1);
    check("dj_third_ignored", int'(jump_pulse), 0);
    check("dj_third_state", int'(state_o), FALL);
    jump = 1'b0; on_ground = 1'b1;
    cyc(1);
    check("dj_land", int'(land_pulse), 1);
    cyc(1);
    jump = 1'b1; cyc(1);
    check("dj_reload", int'(jump_pulse), 1);
    jump = 1'b0; on_ground = 1'b0;
    ys = my;

    // ceiling after three rise pixels
    cnt = 0;
    while (int'(y) != ys - 3 && cnt < 40) begin @(negedge clk); cnt++; end
    ceiling_hit = 1'b1;
    cyc(1);
    check("ceiling_state", int'(state_o), FALL);
    check("ceiling_y", int'(y), ys - 3);
    ceiling_hit = 1'b0;

    // freeze mid-rise; a jump press during freeze becomes an edge afterwards
    on_ground = 1'b1; cyc(1);
    jump = 1'b1; cyc(1);
    jump = 1'b0; on_ground = 1'b0; right = 1'b1;
    cyc(3);
    freeze = 1'b1; cyc(1);
    fx = mx; fy = my; fs = mst;
    jump = 1'b1;
    cyc(49);
    check("freeze_x", int'(x), fx);
    check("freeze_y", int'(y), fy);
    check("freeze_state", int'(state_o), fs);
    check("freeze_no_pulse", int'(jump_pulse), 0);
    freeze = 1'b0; cyc(1);
    check("edge_after_freeze", int'(jump_pulse), 1);
    jump = 1'b0; right = 1'b0;

    // respawn mid-fall
    wait_state(FALL, 200, "pre_respawn_fall");
    cyc(2);
    respawn = 1'b1; cyc(1);
    respawn = 1'b0;
    check("respawn_x", int'(x), 100);
    check("respawn_y", int'(y), 700);
    check("respawn_state", int'(state_o), IDLE);

    // left wall
    on_ground = 1'b1; left = 1'b1;
    cyc(50);
    check("left_wall_x", int'(x), 90);
    check("left_facing", int'(facing_right), 0);
    check("left_anim", int'(anim_frame), 5);

    // walk off a ledge and land on the screen floor
    left = 1'b0; right = 1'b1;
    cyc(2);
    on_ground = 1'b0; cyc(1);
    check("ledge_state", int'(state_o), FALL);
    wait_state(RUN, 200, "floor_land_state");
    check("floor_y", int'(y), 710);
    check("floor_land_pulse", int'(land_pulse), 1);

    // reset mid-run
    on_ground = 1'b1; cyc(5);
    rst = 1'b1; cyc(1);
    check("rst_x", int'(x), 100);
    check("rst_y", int'(y), 700);
    check("rst_state", int'(state_o), IDLE);
    check("rst_anim", int'(anim_frame), 0);
    rst = 1'b0; right = 1'b0;
    cyc(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
